// File: rtl/lsu_port_if.sv
// Core request/response and data-memory signals of the load/store port.
// The slave modport is the LSU; the master modport is the core plus memory side.
interface lsu_port_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_is_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic [3:0]  we;
    logic [31:0] drdata;

    modport slave (
        input  req_valid, req_is_store, req_funct3, req_addr, req_wdata, drdata,
        output req_ready, resp_valid, resp_rdata, resp_err, daddr, dwdata, we
    );

    modport master (
        output req_valid, req_is_store, req_funct3, req_addr, req_wdata, drdata,
        input  req_ready, resp_valid, resp_rdata, resp_err, daddr, dwdata, we
    );
endinterface

// File: rtl/lsu_port.sv
// Byte/half/word load-store port onto a single-cycle word memory.
// Word-crossing accesses take a second memory cycle, or are rejected if disabled.
module lsu_port #(
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input logic      clk,
    input logic      rst_n,
    lsu_port_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;

    state_t      state_q, state_d;
    logic        st_q, st_d;
    logic [2:0]  f3_q, f3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] w0_q, w0_d;
    logic [31:0] w1_q, w1_d;
    logic        err_q, err_d;

    function automatic logic [2:0] size_of(input logic [2:0] f3);
        unique case (f3[1:0])
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic is_legal(input logic st, input logic [2:0] f3);
        if (st) return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
        return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
               (f3 == 3'b100) || (f3 == 3'b101);
    endfunction

    function automatic logic is_cross(input logic [1:0] off, input logic [2:0] f3);
        return ({1'b0, off} + size_of(f3)) > 3'd4;
    endfunction

    logic [1:0]  off;
    logic [31:0] base;
    logic [3:0]  smask;
    logic [7:0]  wmask;
    logic [63:0] pair;
    logic [31:0] ldata;

    assign off  = addr_q[1:0];
    assign base = {addr_q[31:2], 2'b00};
    assign wmask = {4'b0000, smask} << off;
    assign pair = {w1_q, w0_q} >> {off, 3'b000};

    always_comb begin
        smask = 4'b1111;
        unique case (f3_q[1:0])
            2'b00:   smask = 4'b0001;
            2'b01:   smask = 4'b0011;
            default: smask = 4'b1111;
        endcase
    end

    always_comb begin
        ldata = pair[31:0];
        unique case (f3_q)
            3'b000:  ldata = {{24{pair[7]}}, pair[7:0]};
            3'b001:  ldata = {{16{pair[15]}}, pair[15:0]};
            3'b100:  ldata = {24'd0, pair[7:0]};
            3'b101:  ldata = {16'd0, pair[15:0]};
            default: ldata = pair[31:0];
        endcase
    end

    always_comb begin
        state_d = state_q;
        st_d    = st_q;
        f3_d    = f3_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        w0_d    = w0_q;
        w1_d    = w1_q;
        err_d   = err_q;
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        bus.resp_rdata = 32'd0;
        bus.resp_err   = 1'b0;
        bus.daddr      = 32'd0;
        bus.dwdata     = 32'd0;
        bus.we         = 4'd0;
        unique case (state_q)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    st_d    = bus.req_is_store;
                    f3_d    = bus.req_funct3;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    w0_d    = 32'd0;
                    w1_d    = 32'd0;
                    if (!is_legal(bus.req_is_store, bus.req_funct3) ||
                        (!ALLOW_MISALIGNED &&
                         is_cross(bus.req_addr[1:0], bus.req_funct3))) begin
                        err_d   = 1'b1;
                        state_d = RESP;
                    end else begin
                        err_d   = 1'b0;
                        state_d = ACC0;
                    end
                end
            end
            ACC0: begin
                bus.daddr = base;
                if (st_q) begin
                    bus.dwdata = wdata_q << {off, 3'b000};
                    bus.we     = wmask[3:0];
                end else begin
                    w0_d = bus.drdata;
                end
                state_d = is_cross(off, f3_q) ? ACC1 : RESP;
            end
            ACC1: begin
                // Next word wraps modulo 2^32 at the top of memory
                bus.daddr = base + 32'd4;
                if (st_q) begin
                    bus.dwdata = wdata_q >> {(3'd4 - {1'b0, off}), 3'b000};
                    bus.we     = wmask[7:4];
                end else begin
                    w1_d = bus.drdata;
                end
                state_d = RESP;
            end
            RESP: begin
                bus.resp_valid = 1'b1;
                bus.resp_err   = err_q;
                bus.resp_rdata = (err_q || st_q) ? 32'd0 : ldata;
                state_d        = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            st_q    <= 1'b0;
            f3_q    <= 3'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            w0_q    <= 32'd0;
            w1_q    <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            st_q    <= st_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            w0_q    <= w0_d;
            w1_q    <= w1_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_lsu_port.sv
// Bench for lsu_port: vector table, multi-cycle corner sequences and
// random traffic against a byte-level reference memory.
module tb_lsu_port;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lsu_port_if bus ();
    lsu_port_if sbus ();

    lsu_port #(.ALLOW_MISALIGNED(1'b1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    lsu_port #(.ALLOW_MISALIGNED(1'b0)) dut_strict (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (sbus)
    );

    // Word memory seen by the main DUT; 256-byte space aliased by daddr[7:2]
    logic [31:0] mem [64];
    logic        poke = 1'b0;
    logic [5:0]  poke_idx = 6'd0;
    logic [31:0] poke_val = 32'd0;

    always @(posedge clk) begin
        if (poke) mem[poke_idx] <= poke_val;
        else
            for (int i = 0; i < 4; i++)
                if (bus.we[i]) mem[bus.daddr[7:2]][8*i +: 8] <= bus.dwdata[8*i +: 8];
    end
    assign bus.drdata  = mem[bus.daddr[7:2]];
    assign sbus.drdata = 32'd0;

    logic [7:0] rmem [256];
    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic poke_word(input int idx, input logic [31:0] val);
        @(negedge clk);
        poke = 1'b1;
        poke_idx = 6'(idx);
        poke_val = val;
        @(posedge clk);
        #1 poke = 1'b0;
        for (int i = 0; i < 4; i++) rmem[idx*4 + i] = val[8*i +: 8];
    endtask

    function automatic int msize(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic bit mlegal(input logic st, input logic [2:0] f3);
        if (st) return f3 <= 3'd2;
        return f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    endfunction

    // Reference: byte-granular access to rmem; updates rmem for stores
    task automatic model(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, output logic [31:0] er,
                         output logic ee, output int el);
        int n;
        logic [31:0] v;
        er = 32'd0;
        ee = 1'b0;
        if (!mlegal(st, f3)) begin
            ee = 1'b1;
            el = 1;
            return;
        end
        n  = msize(f3);
        el = (int'(a[1:0]) + n > 4) ? 3 : 2;
        v  = 32'd0;
        for (int i = 0; i < n; i++) begin
            if (st) rmem[(a + i) & 32'hFF] = wd[8*i +: 8];
            else v = v | (32'(rmem[(a + i) & 32'hFF]) << (8 * i));
        end
        if (!st) begin
            if (f3 == 3'd0 && v[7])  v = v | 32'hFFFFFF00;
            if (f3 == 3'd1 && v[15]) v = v | 32'hFFFF0000;
            er = v;
        end
    endtask

    task automatic do_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] er,
                          input logic ee, input int el, input string nm);
        int lat;
        bit got;
        bit rdy_bad;
        logic [3:0] wes;
        logic [31:0] rd;
        logic e;
        @(negedge clk);
        chk({nm, "_ready"}, 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1;
        bus.req_is_store = st;
        bus.req_funct3 = f3;
        bus.req_addr = a;
        bus.req_wdata = wd;
        @(posedge clk);
        #1;
        // Keep a junk request asserted while busy; it must be ignored
        bus.req_is_store = 1'($urandom);
        bus.req_funct3 = 3'($urandom);
        bus.req_addr = $urandom;
        bus.req_wdata = $urandom;
        lat = 0;
        got = 0;
        rdy_bad = 0;
        wes = 4'd0;
        rd = 32'd0;
        e = 1'b0;
        while (!got && lat < 8) begin
            lat++;
            wes = wes | bus.we;
            if (bus.resp_valid) begin
                got = 1;
                rd = bus.resp_rdata;
                e = bus.resp_err;
            end else begin
                if (bus.req_ready) rdy_bad = 1;
                @(posedge clk);
                #1;
            end
        end
        bus.req_valid = 1'b0;
        if (!got) lat = 99;
        chk({nm, "_lat"}, 32'(lat), 32'(el));
        chk({nm, "_rdata"}, rd, er);
        chk({nm, "_err"}, 32'(e), 32'(ee));
        chk({nm, "_busy_ready"}, 32'(rdy_bad), 32'd0);
        if (ee || !st) chk({nm, "_we"}, 32'(wes), 32'd0);
        @(posedge clk);
        #1;
        chk({nm, "_pulse"}, {31'd0, bus.resp_valid} | bus.resp_rdata, 32'd0);
    endtask

    task automatic strict_req(input logic [2:0] f3, input logic [31:0] a,
                              input logic ee, input int el, input string nm);
        int lat;
        bit got;
        bit acc;
        logic e;
        @(negedge clk);
        sbus.req_valid = 1'b1;
        sbus.req_is_store = 1'b0;
        sbus.req_funct3 = f3;
        sbus.req_addr = a;
        @(posedge clk);
        #1 sbus.req_valid = 1'b0;
        lat = 0;
        got = 0;
        acc = 0;
        e = 1'b0;
        while (!got && lat < 8) begin
            lat++;
            if (sbus.we != 4'd0 || sbus.daddr != 32'd0) acc = 1;
            if (sbus.resp_valid) begin
                got = 1;
                e = sbus.resp_err;
            end else begin
                @(posedge clk);
                #1;
            end
        end
        if (!got) lat = 99;
        chk({nm, "_lat"}, 32'(lat), 32'(el));
        chk({nm, "_err"}, 32'(e), 32'(ee));
        if (ee) chk({nm, "_noacc"}, 32'(acc), 32'd0);
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } vec_t;

    initial begin
        vec_t tbl[$];
        logic [31:0] er;
        logic ee;
        int el;
        int bad;
        logic st;
        logic [2:0] f3;
        logic [31:0] a, wd;

        tbl.push_back('{1'b0, 3'd0, 32'h00000011, 32'h0, 32'hFFFFFFAA, 1'b0, 2});
        tbl.push_back('{1'b0, 3'd4, 32'h00000011, 32'h0, 32'h000000AA, 1'b0, 2});
        tbl.push_back('{1'b0, 3'd1, 32'h00000012, 32'h0, 32'hFFFF8899, 1'b0, 2});
        tbl.push_back('{1'b0, 3'd5, 32'h00000013, 32'h0, 32'h00000088, 1'b0, 3});
        tbl.push_back('{1'b0, 3'd2, 32'h00000010, 32'h0, 32'h8899AABB, 1'b0, 2});
        tbl.push_back('{1'b0, 3'd1, 32'hFFFFFFFF, 32'h0, 32'h00007F80, 1'b0, 3});
        tbl.push_back('{1'b0, 3'd2, 32'hFFFFFFFD, 32'h0, 32'h7F800000, 1'b0, 3});
        tbl.push_back('{1'b0, 3'd3, 32'h00000010, 32'h0, 32'h0, 1'b1, 1});
        tbl.push_back('{1'b0, 3'd7, 32'h00000010, 32'h0, 32'h0, 1'b1, 1});
        tbl.push_back('{1'b1, 3'd4, 32'h00000010, 32'hDEADBEEF, 32'h0, 1'b1, 1});
        tbl.push_back('{1'b1, 3'd3, 32'h00000010, 32'hDEADBEEF, 32'h0, 1'b1, 1});
        tbl.push_back('{1'b1, 3'd1, 32'h00000021, 32'h1234BEEF, 32'h0, 1'b0, 2});
        tbl.push_back('{1'b1, 3'd0, 32'h00000023, 32'hFFFFFF5A, 32'h0, 1'b0, 2});
        tbl.push_back('{1'b0, 3'd2, 32'h00000020, 32'h0, 32'h5ABEEF00, 1'b0, 2});
        tbl.push_back('{1'b0, 3'd0, 32'h00000022, 32'h0, 32'hFFFFFFBE, 1'b0, 2});
        tbl.push_back('{1'b0, 3'd5, 32'h00000022, 32'h0, 32'h00005ABE, 1'b0, 2});

        bus.req_valid = 1'b0;
        bus.req_is_store = 1'b0;
        bus.req_funct3 = 3'd0;
        bus.req_addr = 32'd0;
        bus.req_wdata = 32'd0;
        sbus.req_valid = 1'b0;
        sbus.req_is_store = 1'b0;
        sbus.req_funct3 = 3'd0;
        sbus.req_addr = 32'd0;
        sbus.req_wdata = 32'd0;

        #12;
        chk("rst_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_resp", {30'd0, bus.resp_valid, bus.resp_err}, 32'd0);
        chk("rst_rdata", bus.resp_rdata, 32'd0);
        chk("rst_bus", bus.daddr | bus.dwdata | 32'(bus.we), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 64; i++) poke_word(i, 32'd0);
        poke_word(4, 32'h8899AABB);
        poke_word(0, 32'h0000007F);
        poke_word(63, 32'h80000000);

        foreach (tbl[i]) begin
            model(tbl[i].st, tbl[i].f3, tbl[i].addr, tbl[i].wdata, er, ee, el);
            do_req(tbl[i].st, tbl[i].f3, tbl[i].addr, tbl[i].wdata,
                   tbl[i].rdata, tbl[i].err, tbl[i].lat, $sformatf("vec%0d", i));
        end

        // Crossing SW: lane enables and data for both memory cycles
        poke_word(3, 32'd0);
        poke_word(4, 32'd0);
        model(1'b1, 3'd2, 32'h0E, 32'h11223344, er, ee, el);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_is_store = 1'b1;
        bus.req_funct3 = 3'd2;
        bus.req_addr = 32'h0E;
        bus.req_wdata = 32'h11223344;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        chk("sw_acc0_daddr", bus.daddr, 32'h0C);
        chk("sw_acc0_we", 32'(bus.we), 32'hC);
        chk("sw_acc0_wd", bus.dwdata, 32'h33440000);
        @(posedge clk);
        #1;
        chk("sw_acc1_daddr", bus.daddr, 32'h10);
        chk("sw_acc1_we", 32'(bus.we), 32'h3);
        chk("sw_acc1_wd", bus.dwdata, 32'h00001122);
        @(posedge clk);
        #1;
        chk("sw_resp_t3", 32'(bus.resp_valid), 32'd1);
        @(posedge clk);
        #1;
        chk("sw_mem0c", mem[3], 32'h33440000);
        chk("sw_mem10", mem[4], 32'h00001122);

        // Reset in the second cycle of a crossing store
        poke_word(11, 32'd0);
        poke_word(12, 32'd0);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_is_store = 1'b1;
        bus.req_funct3 = 3'd2;
        bus.req_addr = 32'h2E;
        bus.req_wdata = 32'hAABBCCDD;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_acc1_we", 32'(bus.we), 32'd0);
        chk("rst_acc1_daddr", bus.daddr, 32'd0);
        chk("rst_acc1_ready", 32'(bus.req_ready), 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        repeat (3) begin
            @(posedge clk);
            #1 if (bus.resp_valid) bad++;
        end
        chk("rst_no_resp", 32'(bad), 32'd0);
        chk("rst_mem2c", mem[11], 32'hCCDD0000);
        chk("rst_mem30", mem[12], 32'd0);
        rmem[8'h2E] = 8'hDD;
        rmem[8'h2F] = 8'hCC;
        do_req(1'b0, 3'd2, 32'h2C, 32'h0, 32'hCCDD0000, 1'b0, 2, "post_rst_lw");
        do_req(1'b0, 3'd5, 32'h2F, 32'h0, 32'h000000CC, 1'b0, 3, "post_rst_lhu");

        strict_req(3'd2, 32'h02, 1'b1, 1, "strict_lw02");
        strict_req(3'd1, 32'h03, 1'b1, 1, "strict_lh03");
        strict_req(3'd2, 32'h04, 1'b0, 2, "strict_lw04");
        strict_req(3'd0, 32'h03, 1'b0, 2, "strict_lb03");

        for (int i = 0; i < 200; i++) begin
            st = 1'($urandom);
            f3 = ($urandom_range(0, 9) == 0) ? 3'($urandom) : 3'($urandom_range(0, 2));
            if (!st && $urandom_range(0, 1) == 1 && f3 != 3'd2) f3 = f3 | 3'd4;
            a = ($urandom_range(0, 3) == 0) ? 32'hFFFFFF00 : 32'h0;
            a = a | 32'($urandom_range(0, 255));
            wd = $urandom;
            model(st, f3, a, wd, er, ee, el);
            do_req(st, f3, a, wd, er, ee, el, $sformatf("rnd%0d", i));
        end

        bad = 0;
        for (int i = 0; i < 64; i++)
            if (mem[i] !== {rmem[4*i+3], rmem[4*i+2], rmem[4*i+1], rmem[4*i]}) bad++;
        chk("final_mem_words", 32'(bad), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
